// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL supervisor: FSM state encoding, relock
// counter width and a helper that sizes the shared phase timer.
package pll_seq_pkg;

  // Encodings are visible on the debug state port, so they are fixed.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_e;

  localparam int unsigned RELOCK_W = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

  // One timer serves every timed state, so it is sized for the longest
  // interval. The timer only ever holds values up to (length - 1).
  function automatic int unsigned cnt_width(input int unsigned len_a,
                                            input int unsigned len_b,
                                            input int unsigned len_c);
    int unsigned longest;
    longest = len_a;
    if (len_b > longest) longest = len_b;
    if (len_c > longest) longest = len_c;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/phase_acc_ce.sv
// One fractional clock-enable channel: a phase accumulator whose carry out
// becomes a single-cycle strobe. Average strobe rate is inc / 2^ACC_W per
// clock with no cumulative drift, because the remainder stays in acc_q.
module phase_acc_ce
  import pll_seq_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q;
  logic             ce_q;
  logic [ACC_W:0]   acc_d;

  // Widened sum; the top bit is the carry that becomes the strobe.
  assign acc_d = {1'b0, acc_q} + {1'b0, inc};

  // Accumulate while enabled; any cycle without enable drops the strobe so
  // the supervisor can silence the channel on the same edge it leaves RUN.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else if (en) begin
      acc_q <= acc_d[ACC_W-1:0];
      ce_q  <= acc_d[ACC_W];
    end else begin
      ce_q  <= 1'b0;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/pll_clk_seq.sv
// PLL supervisor and fractional clock-enable generator.
// Holds the PLL in reset, qualifies its asynchronous locked flag through a
// synchroniser and a stability window, retries on timeout, and once lock is
// trusted drives NUM_CH phase-aligned strobes from per-channel increments.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RESET_PLL  | pll_rst high for RST_PULSE cycles
// WAIT_LOCK  | waiting for synchronised lock; re-reset after LOCK_TIMEOUT
// STABLE     | counting consecutive locked cycles up to LOCK_STABLE
// ALIGN      | one cycle: latch increments, clear all accumulators
// RUN        | ready high, strobes running; any lock loss re-resets the PLL
module pll_clk_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  output logic                    pll_rst,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic [RELOCK_W-1:0]     relock_cnt,
  output logic [2:0]              state
);

  localparam int unsigned CNT_W = cnt_width(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [1:0]              sync_q;
  logic                    lk;
  pll_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    pll_rst_q;
  logic                    ready_q;
  logic [RELOCK_W-1:0]     relock_q;
  logic [RELOCK_W-1:0]     relock_d;
  logic [NUM_CH*ACC_W-1:0] inc_lat_q;
  logic                    acc_en;
  logic                    acc_clr;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lk = sync_q[1];

  assign cnt_d    = cnt_q + CNT_ONE;
  assign relock_d = (relock_q == RELOCK_MAX) ? relock_q : relock_q + RELOCK_W'(1);

  // Supervisor FSM; the shared timer restarts from zero on every state entry.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      relock_q  <= '0;
      inc_lat_q <= '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == PULSE_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so a lock arriving on the timeout cycle wins.
          if (lk) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            relock_q  <= relock_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_STABLE: begin
          // A dropout here is treated as lock chatter, not a lost PLL: the
          // timeout window restarts but the PLL is not reset.
          if (!lk) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= ST_ALIGN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ALIGN: begin
          state_q   <= ST_RUN;
          cnt_q     <= '0;
          ready_q   <= 1'b1;
          inc_lat_q <= inc;
        end
        ST_RUN: begin
          if (!lk) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            relock_q  <= relock_d;
          end
        end
        default: begin
          state_q   <= ST_RESET_PLL;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes advance only in RUN with lock still present, so the edge that
  // leaves RUN on lock loss also clears every ce.
  assign acc_en  = (state_q == ST_RUN) && lk;
  assign acc_clr = (state_q == ST_ALIGN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    phase_acc_ce #(
      .ACC_W (ACC_W)
    ) u_acc (
      .refclk (refclk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .inc    (inc_lat_q[k*ACC_W +: ACC_W]),
      .ce     (ce[k])
    );
  end

  assign pll_rst    = pll_rst_q;
  assign ready      = ready_q;
  assign relock_cnt = relock_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_clk_seq.sv
// Bench for pll_clk_seq: directed scenarios plus a random lock/reset/inc
// stream, every cycle compared against a duration-based behavioural model.
module tb_pll_clk_seq;

  localparam int NUM_CH       = 2;
  localparam int ACC_W        = 8;
  localparam int RST_PULSE    = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_ALIGN  = 3;
  localparam int P_RUN    = 4;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic [15:0] inc;
  logic        pll_rst;
  logic        ready;
  logic [1:0]  ce;
  logic [7:0]  relock_cnt;
  logic [2:0]  state;

  always #5 refclk = ~refclk;

  pll_clk_seq #(
    .NUM_CH       (NUM_CH),
    .ACC_W        (ACC_W),
    .RST_PULSE    (RST_PULSE),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .inc        (inc),
    .pll_rst    (pll_rst),
    .ready      (ready),
    .ce         (ce),
    .relock_cnt (relock_cnt),
    .state      (state)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: phase plus elapsed time in that phase.
  int          m_phase = P_RESET;
  int          m_age   = 0;
  int          m_relock = 0;
  longint      m_steps = 0;
  longint      m_lat [2];
  logic [1:0]  m_ce = 2'b00;
  logic [1:0]  m_pipe = 2'b00;

  int          trace_code = 0;
  logic [2:0]  last_state = 3'b111;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // True when the running total step*s crosses a multiple of 2^ACC_W at step s.
  function automatic bit wraps(input longint s, input longint step);
    return ((s * step) >> ACC_W) != (((s - 1) * step) >> ACC_W);
  endfunction

  task automatic model_edge(input logic r, input logic locked, input logic [15:0] in_v);
    logic lk;
    lk     = m_pipe[1];
    m_pipe = {m_pipe[0], locked};
    m_ce   = 2'b00;
    if (!r) begin
      m_pipe   = 2'b00;
      m_phase  = P_RESET;
      m_age    = 0;
      m_relock = 0;
      m_steps  = 0;
      return;
    end
    case (m_phase)
      P_RESET: begin
        m_age++;
        if (m_age == RST_PULSE) begin m_phase = P_WAIT; m_age = 0; end
      end
      P_WAIT: begin
        if (lk) begin
          m_phase = P_STABLE; m_age = 0;
        end else begin
          m_age++;
          if (m_age == LOCK_TIMEOUT) begin
            m_phase = P_RESET; m_age = 0;
            if (m_relock < 255) m_relock++;
          end
        end
      end
      P_STABLE: begin
        if (!lk) begin
          m_phase = P_WAIT; m_age = 0;
        end else begin
          m_age++;
          if (m_age == LOCK_STABLE) m_phase = P_ALIGN;
        end
      end
      P_ALIGN: begin
        m_phase  = P_RUN;
        m_lat[0] = longint'(in_v[7:0]);
        m_lat[1] = longint'(in_v[15:8]);
        m_steps  = 0;
      end
      default: begin
        if (!lk) begin
          m_phase = P_RESET; m_age = 0;
          if (m_relock < 255) m_relock++;
        end else begin
          m_steps++;
          for (int k = 0; k < 2; k++) m_ce[k] = wraps(m_steps, m_lat[k]);
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge(rst_n, pll_locked, inc);
    #1;
    cyc++;
    check_val("pll_rst", 32'(pll_rst), 32'(m_phase == P_RESET));
    check_val("ready", 32'(ready), 32'(m_phase == P_RUN));
    check_val("ce", 32'(ce), 32'(m_ce));
    check_val("relock_cnt", 32'(relock_cnt), 32'(m_relock));
    check_val("state", 32'(state), 32'(m_phase));
    if (state !== last_state) begin
      trace_code = trace_code * 10 + int'(state);
      last_state = state;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for ready (use_rdy=1) or pll_rst to reach val.
  task automatic wait_sig(input string tag, input bit use_rdy, input logic val,
                          input int limit, output int n);
    n = 0;
    while (((use_rdy ? ready : pll_rst) !== val) && n < limit) begin
      tick();
      n++;
    end
    check_val({tag, "_reached"}, 32'((use_rdy ? ready : pll_rst) === val), 32'd1);
  endtask

  function automatic logic [7:0] rand_lane();
    return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, run_n, first0, first1, last0, last1, rises, last_rise, cnt;
    int pulses[$];
    logic prev;

    rst_n = 1'b0; pll_locked = 1'b0; inc = '0;

    // Reset values and post-release reset pulse.
    ticks(3);
    check_val("rst_pll_rst", 32'(pll_rst), 32'd1);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_ce", 32'(ce), 32'd0);
    check_val("rst_relock", 32'(relock_cnt), 32'd0);
    check_val("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    wait_sig("rst_release", 1'b0, 1'b0, 20, n);
    check_val("rst_pulse_len", 32'(n), 32'd4);
    check_val("wait_state", 32'(state), 32'd1);

    // Clean lock with inc = {128, 64}.
    inc = {8'd128, 8'd64};
    ticks(5);
    pll_locked = 1'b1;
    wait_sig("clean_lock", 1'b1, 1'b1, 40, n);
    check_val("clean_ready_lat", 32'(n), 32'd12);
    first0 = -1; first1 = -1; last0 = -1; last1 = -1; run_n = 1;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) inc = 16'($urandom);
      tick();
      run_n++;
      if (ce[0] === 1'b1) begin
        if (first0 < 0) first0 = run_n; else check_val("ce0_gap", 32'(run_n - last0), 32'd4);
        last0 = run_n;
      end
      if (ce[1] === 1'b1) begin
        if (first1 < 0) first1 = run_n; else check_val("ce1_gap", 32'(run_n - last1), 32'd2);
        last1 = run_n;
      end
    end
    check_val("ce0_first", 32'(first0), 32'd5);
    check_val("ce1_first", 32'(first1), 32'd3);

    // Loss of lock in RUN.
    pll_locked = 1'b0;
    wait_sig("loss", 1'b1, 1'b0, 10, n);
    check_val("loss_latency", 32'(n), 32'd3);
    check_val("loss_ce", 32'(ce), 32'd0);
    check_val("loss_pll_rst", 32'(pll_rst), 32'd1);
    wait_sig("loss_pulse", 1'b0, 1'b0, 20, n);
    check_val("loss_pulse_len", 32'(n), 32'd4);
    check_val("loss_relock", 32'(relock_cnt), 32'd1);

    // Glitchy lock: high 5, low 1, high again.
    inc = {rand_lane(), rand_lane()};
    ticks($urandom_range(0, 10));
    trace_code = int'(state);
    last_state = state;
    pll_locked = 1'b1;
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_sig("glitch", 1'b1, 1'b1, 40, n);
    check_val("glitch_ready_lat", 32'(n), 32'd12);
    check_val("glitch_trace", 32'(trace_code), 32'd121234);
    check_val("glitch_relock", 32'(relock_cnt), 32'd1);

    // Fractional rate: inc = 3 on channel 0.
    pll_locked = 1'b0;
    wait_sig("frac_drop", 1'b0, 1'b1, 10, n);
    wait_sig("frac_pulse", 1'b0, 1'b0, 10, n);
    inc = {rand_lane(), 8'd3};
    pll_locked = 1'b1;
    wait_sig("frac_lock", 1'b1, 1'b1, 40, n);
    run_n = 1;
    for (int i = 0; i < 769; i++) begin
      if (i == 100) inc = 16'($urandom);
      tick();
      run_n++;
      if (ce[0] === 1'b1) pulses.push_back(run_n);
    end
    check_val("frac_count", 32'(pulses.size()), 32'd9);
    if (pulses.size() > 0) check_val("frac_first", 32'(pulses[0]), 32'd87);
    for (int i = 1; i < pulses.size(); i++)
      check_val("frac_gap", 32'(pulses[i] - pulses[i-1]), (i % 3 == 0) ? 32'd86 : 32'd85);
    for (int j = 0; j < 3; j++) begin
      cnt = 0;
      foreach (pulses[i]) if (pulses[i] >= 2 + 256*j && pulses[i] <= 257 + 256*j) cnt++;
      check_val("frac_window", 32'(cnt), 32'd3);
    end

    // Random lock/reset/increment stream.
    for (int seg = 0; seg < 120; seg++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst_n = 1'b0;
        ticks($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      pll_locked = (r % 3 != 0);
      if ($urandom_range(0, 3) == 0) inc = {rand_lane(), rand_lane()};
      ticks($urandom_range(1, 45));
    end

    // Repeated timeouts from a fresh reset, up to relock saturation.
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    pll_locked = 1'b0;
    rises = 0; last_rise = -1;
    for (int i = 0; i < 300*36 + 200 && rises < 300; i++) begin
      prev = pll_rst;
      tick();
      if (prev === 1'b0 && pll_rst === 1'b1) begin
        rises++;
        if (rises <= 3) check_val("relock_step", 32'(relock_cnt), 32'(rises));
        if (rises <= 5 && last_rise >= 0) check_val("retry_period", 32'(cyc - last_rise), 32'd36);
        last_rise = cyc;
      end
    end
    check_val("timeout_count", 32'(rises), 32'd300);
    check_val("relock_sat", 32'(relock_cnt), 32'd255);
    ticks(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
